game_controller_multi: RTL and testbench
========================================

Name: game_controller_multi

Overview:
- Parametrised successor game FSM for the frog VGA game.
- Arbitrates N hazard draw requests plus frog and end-bank into a zero-latency mux select.
- Detects frog/hazard collisions (lose) and frog/end-bank contact (win), and tracks level and lives.
- Times a win/lose/game-over sound burst and drives a level-dependent object-enable mask to the object generators.

Parameters:
- NUM_HAZARDS, 4, number of hazard draw-request channels (waterfalls, logs, etc.); 1..250
- NUM_LIVES, 3, lives at reset and on restart; >=1
- MAX_LEVEL, 15, level saturation value; level range 1..MAX_LEVEL
- OBJ_NUM, 16, width of obj_enable mask
- BUZ_CYCLES, 50000000, sound burst length in clk cycles; >=1
- WIN_FREQ, 1, sound_freq code on win
- LOSE_FREQ, 0, sound_freq code on life lost
- OVER_FREQ, 2, sound_freq code on game over

Ports:
- clk  in  1  system clock
- resetN  in  1  reset, asynchronous, active-low
- start  in  1  restart request, sampled only in OVER
- hazard_draw_req  in  NUM_HAZARDS  per-hazard pixel request; bit 0 highest priority
- frog_draw_req  in  1  frog pixel request
- endbank_draw_req  in  1  end-bank pixel request
- select_mux  out  8  drawing object select
- win  out  1  one-cycle pulse on level completion
- lose  out  1  one-cycle pulse on life lost
- game_over  out  1  high while in OVER
- level  out  $clog2(MAX_LEVEL+1)  current level
- lives  out  $clog2(NUM_LIVES+1)  remaining lives
- sound_freq  out  10  tone code, registered
- enable_sound  out  1  high during sound burst
- obj_enable  out  OBJ_NUM  thermometer mask, low min(level,OBJ_NUM) bits set

Behaviour:
- Reset values: state PLAY, level=1, lives=NUM_LIVES, sound_freq=LOSE_FREQ, buzz counter=0, win=lose=enable_sound=game_over=0, obj_enable=1, select_mux=0.
- select_mux is combinational from the current inputs (0 cycle latency) in every state.
  - Priority: lowest-index asserted hazard i gives 1+i; else frog gives NUM_HAZARDS+1; else endbank gives NUM_HAZARDS+2; else 0 (background).
- States: PLAY, WIN, LOSE, BUZ, OVER.
- PLAY:
  - Any hazard_draw_req & frog_draw_req goes to LOSE.
  - Else frog_draw_req & endbank_draw_req goes to WIN.
  - If both conditions are true in the same cycle, LOSE wins.
- WIN, 1 cycle:
  - win=1.
  - level <= min(level+1, MAX_LEVEL). At MAX_LEVEL the level holds and win still pulses.
  - sound_freq <= WIN_FREQ; load counter=BUZ_CYCLES-1; next state BUZ.
- LOSE, 1 cycle:
  - lose=1; lives <= lives-1; level <= max(level-1, 1).
  - If lives==1 (becomes 0): sound_freq <= OVER_FREQ. Otherwise sound_freq <= LOSE_FREQ.
  - Load counter=BUZ_CYCLES-1; next state BUZ.
- BUZ:
  - enable_sound=1. Counter decrements each cycle.
  - Exit in the cycle the counter equals 0, giving exactly BUZ_CYCLES cycles of enable_sound.
  - Exit to OVER if lives==0, else to PLAY.
  - Collisions are ignored during BUZ.
- OVER:
  - game_over=1, enable_sound=0; collisions ignored.
  - start=1 reloads lives=NUM_LIVES and level=1, then goes to PLAY next cycle.
  - start is ignored in all other states.
- obj_enable is registered and updated in the same cycle as level.
- Counter width is $clog2(BUZ_CYCLES+1); all arithmetic saturates, with no wrap on level or lives.
- resetN low at any point, including mid-BUZ, returns immediately to the reset values.
- Inputs are synchronous to clk; no internal synchronisers.

Test Plan:
Bench parameters: NUM_HAZARDS=3, NUM_LIVES=2, MAX_LEVEL=3, OBJ_NUM=4, BUZ_CYCLES=5.
- Priority mux: hazard_req=3'b110 with frog=1 → select_mux=2. hazard_req=0, frog=1, endbank=1 → select_mux=4. Only endbank → 5. Nothing asserted → 0.
- Win path: frog+endbank for 1 cycle in PLAY → win pulses 1 cycle, level 1→2, obj_enable=4'b0011, sound_freq=1, enable_sound high exactly 5 cycles, then PLAY.
- Level saturation: three consecutive wins → level stays 3, win pulses each time, obj_enable=4'b0111.
- Simultaneous: hazard_req[1], frog and endbank in the same cycle → lose pulses, win stays 0, lives 2→1, level 1 stays 1, sound_freq=0.
- Game over: second loss → sound_freq=2, 5 buzz cycles, game_over=1. Collisions are then ignored. start=1 → next cycle PLAY with lives=2, level=1.
- Reset mid-BUZ: resetN low in the 3rd buzz cycle → enable_sound=0, state PLAY, and all outputs at reset values asynchronously.

Source files
------------

// File: rtl/game_controller_multi.sv
// Frog game controller: hazard/frog/end-bank pixel arbitration, collision-driven
// win/lose FSM with level and lives tracking, sound burst timing and object-enable mask.
module game_controller_multi #(
    parameter int NUM_HAZARDS = 4,
    parameter int NUM_LIVES   = 3,
    parameter int MAX_LEVEL   = 15,
    parameter int OBJ_NUM     = 16,
    parameter int BUZ_CYCLES  = 50000000,
    parameter int WIN_FREQ    = 1,
    parameter int LOSE_FREQ   = 0,
    parameter int OVER_FREQ   = 2
) (
    input  logic                           clk,
    input  logic                           resetN,
    input  logic                           start,
    input  logic [NUM_HAZARDS-1:0]         hazard_draw_req,
    input  logic                           frog_draw_req,
    input  logic                           endbank_draw_req,
    output logic [7:0]                     select_mux,
    output logic                           win,
    output logic                           lose,
    output logic                           game_over,
    output logic [$clog2(MAX_LEVEL+1)-1:0] level,
    output logic [$clog2(NUM_LIVES+1)-1:0] lives,
    output logic [9:0]                     sound_freq,
    output logic                           enable_sound,
    output logic [OBJ_NUM-1:0]             obj_enable
);

    localparam int LW  = $clog2(MAX_LEVEL + 1);
    localparam int LVW = $clog2(NUM_LIVES + 1);
    localparam int CW  = $clog2(BUZ_CYCLES + 1);

    typedef enum logic [2:0] {
        S_PLAY,
        S_WIN,
        S_LOSE,
        S_BUZ,
        S_OVER
    } state_t;

    state_t          state;
    logic [CW-1:0]   buz_cnt;
    logic            hit_hazard;
    logic            hit_endbank;
    logic            mux_found;
    logic [LW-1:0]   level_up;
    logic [LW-1:0]   level_down;

    // Thermometer of the level, clipped to the mask width.
    function automatic logic [OBJ_NUM-1:0] level_mask(input logic [LW-1:0] lv);
        logic [OBJ_NUM-1:0] m;
        m = '0;
        for (int j = 0; j < OBJ_NUM; j++) begin
            m[j] = (j < int'(lv));
        end
        return m;
    endfunction

    // Zero-latency draw arbitration; the lowest hazard index wins.
    always_comb begin
        select_mux = 8'd0;
        mux_found  = 1'b0;
        for (int i = 0; i < NUM_HAZARDS; i++) begin
            if (!mux_found && hazard_draw_req[i]) begin
                select_mux = 8'(i + 1);
                mux_found  = 1'b1;
            end
        end
        if (!mux_found) begin
            if (frog_draw_req) begin
                select_mux = 8'(NUM_HAZARDS + 1);
            end else if (endbank_draw_req) begin
                select_mux = 8'(NUM_HAZARDS + 2);
            end
        end
    end

    assign hit_hazard  = (|hazard_draw_req) & frog_draw_req;
    assign hit_endbank = frog_draw_req & endbank_draw_req;

    assign level_up   = (level >= LW'(MAX_LEVEL)) ? level : level + LW'(1);
    assign level_down = (level <= LW'(1)) ? LW'(1) : level - LW'(1);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= S_PLAY;
            level        <= LW'(1);
            lives        <= LVW'(NUM_LIVES);
            sound_freq   <= 10'(LOSE_FREQ);
            buz_cnt      <= '0;
            win          <= 1'b0;
            lose         <= 1'b0;
            enable_sound <= 1'b0;
            game_over    <= 1'b0;
            obj_enable   <= OBJ_NUM'(1);
        end else begin
            win  <= 1'b0;
            lose <= 1'b0;
            case (state)
                S_PLAY: begin
                    // A hazard hit takes precedence over reaching the bank.
                    if (hit_hazard) begin
                        state <= S_LOSE;
                        lose  <= 1'b1;
                    end else if (hit_endbank) begin
                        state <= S_WIN;
                        win   <= 1'b1;
                    end
                end
                S_WIN: begin
                    level        <= level_up;
                    obj_enable   <= level_mask(level_up);
                    sound_freq   <= 10'(WIN_FREQ);
                    buz_cnt      <= CW'(BUZ_CYCLES - 1);
                    enable_sound <= 1'b1;
                    state        <= S_BUZ;
                end
                S_LOSE: begin
                    lives        <= (lives == '0) ? '0 : lives - LVW'(1);
                    level        <= level_down;
                    obj_enable   <= level_mask(level_down);
                    sound_freq   <= (lives == LVW'(1)) ? 10'(OVER_FREQ) : 10'(LOSE_FREQ);
                    buz_cnt      <= CW'(BUZ_CYCLES - 1);
                    enable_sound <= 1'b1;
                    state        <= S_BUZ;
                end
                S_BUZ: begin
                    if (buz_cnt == '0) begin
                        enable_sound <= 1'b0;
                        if (lives == '0) begin
                            state     <= S_OVER;
                            game_over <= 1'b1;
                        end else begin
                            state <= S_PLAY;
                        end
                    end else begin
                        buz_cnt <= buz_cnt - CW'(1);
                    end
                end
                S_OVER: begin
                    if (start) begin
                        lives      <= LVW'(NUM_LIVES);
                        level      <= LW'(1);
                        obj_enable <= level_mask(LW'(1));
                        game_over  <= 1'b0;
                        state      <= S_PLAY;
                    end
                end
                default: state <= S_PLAY;
            endcase
        end
    end

endmodule

// File: tb/tb_game_controller_multi.sv
// Directed bench for game_controller_multi: mux vector table plus win/lose/over/reset sequences.
module tb_game_controller_multi;

    logic       clk = 1'b0;
    logic       resetN;
    logic       start;
    logic [2:0] hazard_draw_req;
    logic       frog_draw_req;
    logic       endbank_draw_req;
    logic [7:0] select_mux;
    logic       win, lose, game_over, enable_sound;
    logic [1:0] level;
    logic [1:0] lives;
    logic [9:0] sound_freq;
    logic [3:0] obj_enable;

    int errors = 0;
    int checks = 0;

    game_controller_multi #(
        .NUM_HAZARDS(3), .NUM_LIVES(2), .MAX_LEVEL(3), .OBJ_NUM(4),
        .BUZ_CYCLES(5), .WIN_FREQ(1), .LOSE_FREQ(0), .OVER_FREQ(2)
    ) dut (
        .clk(clk), .resetN(resetN), .start(start),
        .hazard_draw_req(hazard_draw_req), .frog_draw_req(frog_draw_req),
        .endbank_draw_req(endbank_draw_req), .select_mux(select_mux),
        .win(win), .lose(lose), .game_over(game_over), .level(level),
        .lives(lives), .sound_freq(sound_freq), .enable_sound(enable_sound),
        .obj_enable(obj_enable)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] haz;
        logic       frog;
        logic       eb;
        logic [7:0] exp_sel;
    } mux_vec_t;

    mux_vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        hazard_draw_req  = 3'b000;
        frog_draw_req    = 1'b0;
        endbank_draw_req = 1'b0;
        start            = 1'b0;
    endtask

    // Count consecutive enable_sound samples starting at the current negedge.
    task automatic count_buzz(output int n);
        n = 0;
        while (enable_sound && n < 20) begin
            n++;
            @(negedge clk);
        end
    endtask

    // One-cycle collision in PLAY, then check the pulse, post-event state and burst length.
    task automatic collide(input string tag, input logic [2:0] haz, input logic frog, input logic eb,
                           input int exp_win, input int exp_lose, input int exp_level,
                           input int exp_lives, input int exp_obj, input int exp_sf,
                           input int exp_over);
        int n;
        @(negedge clk);
        hazard_draw_req  = haz;
        frog_draw_req    = frog;
        endbank_draw_req = eb;
        @(negedge clk);
        clear_inputs();
        check({tag, " win pulse"}, int'(win), exp_win);
        check({tag, " lose pulse"}, int'(lose), exp_lose);
        @(negedge clk);
        check({tag, " win cleared"}, int'(win), 0);
        check({tag, " lose cleared"}, int'(lose), 0);
        check({tag, " level"}, int'(level), exp_level);
        check({tag, " lives"}, int'(lives), exp_lives);
        check({tag, " obj_enable"}, int'(obj_enable), exp_obj);
        check({tag, " sound_freq"}, int'(sound_freq), exp_sf);
        count_buzz(n);
        check({tag, " buzz cycles"}, n, 5);
        check({tag, " game_over after buzz"}, int'(game_over), exp_over);
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        resetN = 1'b1;
    endtask

    initial begin
        int n;
        vecs[0] = '{3'b110, 1'b1, 1'b0, 8'd2};
        vecs[1] = '{3'b000, 1'b1, 1'b1, 8'd4};
        vecs[2] = '{3'b000, 1'b0, 1'b1, 8'd5};
        vecs[3] = '{3'b000, 1'b0, 1'b0, 8'd0};
        vecs[4] = '{3'b101, 1'b1, 1'b1, 8'd1};
        vecs[5] = '{3'b100, 1'b0, 1'b0, 8'd3};
        vecs[6] = '{3'b000, 1'b1, 1'b0, 8'd4};

        do_reset();
        @(negedge clk);
        check("reset level", int'(level), 1);
        check("reset lives", int'(lives), 2);
        check("reset sound_freq", int'(sound_freq), 0);
        check("reset win", int'(win), 0);
        check("reset lose", int'(lose), 0);
        check("reset enable_sound", int'(enable_sound), 0);
        check("reset game_over", int'(game_over), 0);
        check("reset obj_enable", int'(obj_enable), 1);

        // Inputs are cleared before the next rising edge so the FSM never sees them.
        foreach (vecs[i]) begin
            @(negedge clk);
            hazard_draw_req  = vecs[i].haz;
            frog_draw_req    = vecs[i].frog;
            endbank_draw_req = vecs[i].eb;
            #1;
            check($sformatf("mux vec %0d", i), int'(select_mux), int'(vecs[i].exp_sel));
            clear_inputs();
        end
        @(negedge clk);
        check("mux table left state alone", int'(lives), 2);

        collide("win1", 3'b000, 1'b1, 1'b1, 1, 0, 2, 2, 4'b0011, 1, 0);
        collide("win2", 3'b000, 1'b1, 1'b1, 1, 0, 3, 2, 4'b0111, 1, 0);
        collide("win3 sat", 3'b000, 1'b1, 1'b1, 1, 0, 3, 2, 4'b0111, 1, 0);

        do_reset();
        collide("simul lose", 3'b010, 1'b1, 1'b1, 0, 1, 1, 1, 4'b0001, 0, 0);
        collide("final lose", 3'b001, 1'b1, 1'b0, 0, 1, 1, 0, 4'b0001, 2, 1);

        // Collisions in OVER must not pulse anything.
        @(negedge clk);
        hazard_draw_req = 3'b100; frog_draw_req = 1'b1; endbank_draw_req = 1'b1;
        repeat (2) @(negedge clk);
        check("over ignores lose", int'(lose), 0);
        check("over ignores win", int'(win), 0);
        check("over holds game_over", int'(game_over), 1);
        clear_inputs();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart game_over", int'(game_over), 0);
        check("restart lives", int'(lives), 2);
        check("restart level", int'(level), 1);

        // Win to reach BUZ, then pull reset during the third buzz cycle.
        @(negedge clk);
        frog_draw_req = 1'b1; endbank_draw_req = 1'b1;
        @(negedge clk);
        clear_inputs();
        @(negedge clk);
        check("pre-reset level", int'(level), 2);
        repeat (2) @(negedge clk);
        check("third buzz cycle", int'(enable_sound), 1);
        resetN = 1'b0;
        #1;
        check("async reset enable_sound", int'(enable_sound), 0);
        check("async reset level", int'(level), 1);
        check("async reset obj_enable", int'(obj_enable), 1);
        check("async reset sound_freq", int'(sound_freq), 0);
        check("async reset lives", int'(lives), 2);
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        frog_draw_req = 1'b1; endbank_draw_req = 1'b1;
        @(negedge clk);
        clear_inputs();
        check("post-reset in PLAY (win)", int'(win), 1);
        @(negedge clk);
        count_buzz(n);
        check("post-reset buzz cycles", n, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
